// File: rtl/fft_band_peak_picker.sv
// Per-band peak picker for one FFT magnitude frame: tracks the strongest bin in each band of the
// non-mirrored half, then drains one peak record per band over a valid/ready handshake.
module fft_band_peak_picker #(
    parameter int unsigned FFT_LENGTH = 1024,
    parameter int unsigned MAG_W      = 16,
    parameter int unsigned USED_BINS  = 512,
    parameter int unsigned NUM_BANDS  = 4,
    parameter int unsigned BIN_W      = $clog2(FFT_LENGTH),
    parameter int unsigned BAND_IW    = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [MAG_W-1:0]   mag_i,
    input  logic               mag_valid_i,
    output logic               mag_ready_o,
    input  logic [MAG_W-1:0]   threshold_i,
    output logic [BAND_IW-1:0] peak_band_o,
    output logic [BIN_W-1:0]   peak_bin_o,
    output logic [MAG_W-1:0]   peak_mag_o,
    output logic               peak_above_o,
    output logic               peak_valid_o,
    input  logic               peak_ready_i,
    output logic               frame_done_o,
    output logic               overflow_o,
    input  logic               clear_overflow_i
);

    localparam int unsigned BAND_W = USED_BINS / NUM_BANDS;

    typedef enum logic {StCollect, StDrain} state_e;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [BIN_W-1:0]   r_bin;
    logic [BAND_IW-1:0] r_ptr;
    logic [MAG_W-1:0]   r_thr;
    logic               r_done;
    logic               r_ovf;
    logic [MAG_W-1:0]   r_max    [NUM_BANDS];
    logic [BIN_W-1:0]   r_pk_bin [NUM_BANDS];
    logic [NUM_BANDS-1:0] r_seen;

    logic               w_accept;
    logic               w_last_bin;
    logic               w_rec_acc;
    logic               w_last_rec;
    logic               w_in_use;
    logic [BAND_IW-1:0] w_band;
    logic [BIN_W-1:0]   w_base;

    assign w_accept   = mag_valid_i & mag_ready_o;
    assign w_last_bin = (r_bin == BIN_W'(FFT_LENGTH - 1));
    assign w_rec_acc  = peak_valid_o & peak_ready_i;
    assign w_last_rec = (r_ptr == BAND_IW'(NUM_BANDS - 1));
    assign w_in_use   = (32'(r_bin) < USED_BINS);
    assign w_base     = BIN_W'(32'(r_ptr) * BAND_W);

    generate
        if ((BAND_W & (BAND_W - 1)) == 0) begin : g_band_shift
            assign w_band = BAND_IW'(r_bin >> $clog2(BAND_W));
        end else begin : g_band_cmp
            always_comb begin
                w_band = '0;
                for (int b = 1; b < NUM_BANDS; b++) begin
                    if (32'(r_bin) >= 32'(b) * BAND_W) w_band = BAND_IW'(b);
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= StCollect;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            StCollect: if (w_accept && w_last_bin) w_state_nxt = StDrain;
            StDrain:   if (w_rec_acc && w_last_rec) w_state_nxt = StCollect;
            default:   w_state_nxt = StCollect;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_bin  <= '0;
            r_ptr  <= '0;
            r_thr  <= '0;
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
            r_seen <= '0;
            for (int b = 0; b < NUM_BANDS; b++) begin
                r_max[b]    <= '0;
                r_pk_bin[b] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            // A dropped sample and a clear in the same cycle leave the flag set.
            if (mag_valid_i && !mag_ready_o) r_ovf <= 1'b1;
            else if (clear_overflow_i)       r_ovf <= 1'b0;

            if (w_accept) begin
                r_bin <= r_bin + BIN_W'(1);
                if (w_in_use && (!r_seen[w_band] || mag_i > r_max[w_band])) begin
                    r_seen[w_band]   <= 1'b1;
                    r_max[w_band]    <= mag_i;
                    r_pk_bin[w_band] <= r_bin;
                end
                if (w_last_bin) begin
                    r_ptr <= '0;
                    r_thr <= threshold_i;
                end
            end

            if (w_rec_acc) begin
                r_ptr <= r_ptr + BAND_IW'(1);
                if (w_last_rec) begin
                    r_done <= 1'b1;
                    r_bin  <= '0;
                    r_ptr  <= '0;
                    r_seen <= '0;
                    for (int b = 0; b < NUM_BANDS; b++) begin
                        r_max[b]    <= '0;
                        r_pk_bin[b] <= '0;
                    end
                end
            end
        end
    end

    always_comb begin
        mag_ready_o  = (r_state == StCollect);
        peak_valid_o = (r_state == StDrain);
        peak_band_o  = '0;
        peak_bin_o   = '0;
        peak_mag_o   = '0;
        peak_above_o = 1'b0;
        frame_done_o = r_done;
        overflow_o   = r_ovf;
        if (r_state == StDrain) begin
            peak_band_o  = r_ptr;
            // An unseen band reports its first bin with zero magnitude.
            peak_bin_o   = r_seen[r_ptr] ? r_pk_bin[r_ptr] : w_base;
            peak_mag_o   = r_max[r_ptr];
            peak_above_o = (r_max[r_ptr] >= r_thr);
        end
    end

endmodule
